mxrv_ifetch: RTL and testbench

Instruction fetch stage placed directly downstream of mxrv_pc_reg. Takes the current PC, issues single-outstanding read requests on the instruction bus, and buffers returned words in a small FIFO. Presents {inst, inst_addr} to decode with a valid/ready handshake. Back-pressures pc_reg through fetch_hold_o and flushes on jump_flag_i.

---
 rtl/mxrv_ifetch.sv | 170 +++++++++++++++++
 tb/tb_mxrv_ifetch.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mxrv_ifetch.sv
// mxrv_ifetch - instruction fetch stage downstream of mxrv_pc_reg.
//
// Issues single-outstanding reads on the instruction bus from pc_i and buffers
// returned words with their addresses in a small FIFO. The buffered words go
// to decode over a valid/ready handshake. fetch_hold_o stalls pc_reg until a
// request is granted. jump_flag_i flushes the FIFO and discards any response
// that is still in flight.
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   pc_i                         current PC from pc_reg
//   jump_flag_i                  redirect/flush
//   hold_flag_i                  pipeline stall, blocks new requests only
//   fetch_hold_o                 1 = pc_reg must not advance
//   ibus_req_o/addr_o/gnt_i      request channel
//   ibus_rvalid_i/rdata_i        response channel
//   inst_valid_o/o/addr_o        instruction to decode
//   inst_ready_i                 decode accepts instruction
//
// Optional feature: define MXRV_IFETCH_BYPASS_EN to present a response
// combinationally when the FIFO is empty. This gives zero fetch-to-decode
// latency. The default build uses only the registered path, with 1-cycle latency.
//
// State  | meaning
// IDLE   | no request outstanding, waiting for FIFO space / hold release
// REQ    | ibus_req_o asserted, waiting for gnt
// WAIT   | request granted, response will be kept
// DROP   | request granted before a jump, response will be discarded

module mxrv_ifetch #(
  parameter int                 ADDR_W     = 32,
  parameter int                 DATA_W     = 32,
  parameter int                 FIFO_DEPTH = 2,
  parameter logic [DATA_W-1:0]  RESET_INST = DATA_W'(32'h00000013)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              jump_flag_i,
  input  logic              hold_flag_i,
  output logic              fetch_hold_o,
  output logic              ibus_req_o,
  output logic [ADDR_W-1:0] ibus_addr_o,
  input  logic              ibus_gnt_i,
  input  logic              ibus_rvalid_i,
  input  logic [DATA_W-1:0] ibus_rdata_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              inst_ready_i
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [ADDR_W-1:0] addr_mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;

  logic fifo_empty, rsp_in, byp_vld, byp_take, push, pop, issue_ok;

  assign fifo_empty = (count_q == '0);
  // A response is kept only in WAIT and only if no jump kills it this cycle.
  assign rsp_in     = (state_q == S_WAIT) & ibus_rvalid_i & ~jump_flag_i;

`ifdef MXRV_IFETCH_BYPASS_EN
  assign byp_vld  = fifo_empty & rsp_in;
  assign byp_take = byp_vld & inst_ready_i;
`else
  assign byp_vld  = 1'b0;
  assign byp_take = 1'b0;
`endif

  assign push = rsp_in & ~byp_take;
  assign pop  = ~fifo_empty & inst_ready_i & ~jump_flag_i;

  always_comb begin
    count_d = count_q;
    if (jump_flag_i)
      count_d = '0;
    else if (push & ~pop)
      count_d = count_q + 1'b1;
    else if (~push & pop)
      count_d = count_q - 1'b1;
  end

  // Evaluated after this cycle's push/pop/flush, so a response being
  // retired frees its reserved slot for the next request.
  assign issue_ok = ~hold_flag_i & (count_d < DEPTH_C);

  always_comb begin
    state_d    = state_q;
    ibus_req_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (~hold_flag_i & ~jump_flag_i & (count_q < DEPTH_C))
          state_d = S_REQ;
      end
      S_REQ: begin
        ibus_req_o = 1'b1;
        // Without gnt a jump simply lets the request follow the new pc_i.
        if (ibus_gnt_i)
          state_d = jump_flag_i ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (ibus_rvalid_i)
          state_d = issue_ok ? S_REQ : S_IDLE;
        else if (jump_flag_i)
          state_d = S_DROP;
      end
      S_DROP: begin
        if (ibus_rvalid_i)
          state_d = issue_ok ? S_REQ : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ibus_addr_o  = pc_i;
  assign fetch_hold_o = ~(ibus_req_o & ibus_gnt_i);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pend_addr_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (jump_flag_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (ibus_req_o & ibus_gnt_i)
        pend_addr_q <= pc_i;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= pend_addr_q;
      data_mem_q[wr_ptr_q] <= ibus_rdata_i;
    end
  end

  always_comb begin
    inst_valid_o = ~fifo_empty | byp_vld;
    inst_o       = RESET_INST;
    inst_addr_o  = '0;
    if (~fifo_empty) begin
      inst_o      = data_mem_q[rd_ptr_q];
      inst_addr_o = addr_mem_q[rd_ptr_q];
    end else if (byp_vld) begin
      inst_o      = ibus_rdata_i;
      inst_addr_o = pend_addr_q;
    end
  end

endmodule

// File: tb/tb_mxrv_ifetch.sv
module tb_mxrv_ifetch;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_i;
  logic        jump_flag_i, hold_flag_i, fetch_hold_o;
  logic        ibus_req_o, ibus_gnt_i, ibus_rvalid_i;
  logic [31:0] ibus_addr_o, ibus_rdata_i;
  logic        inst_valid_o, inst_ready_i;
  logic [31:0] inst_o, inst_addr_o;

  always #5 clk = ~clk;

  mxrv_ifetch #(
    .ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(2), .RESET_INST(NOP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pc_i(pc_i), .jump_flag_i(jump_flag_i),
    .hold_flag_i(hold_flag_i), .fetch_hold_o(fetch_hold_o),
    .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o), .ibus_gnt_i(ibus_gnt_i),
    .ibus_rvalid_i(ibus_rvalid_i), .ibus_rdata_i(ibus_rdata_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .inst_ready_i(inst_ready_i)
  );

  int checks = 0;
  int errors = 0;

  // stimulus knobs
  logic        k_rst_n = 1'b0, k_hold = 1'b0, k_ready = 1'b1, k_jump = 1'b0;
  logic [31:0] k_target = 32'h0;
  int          lat = 1;

  // environment: pc_reg and bus slave models
  logic [31:0] pc_m = 32'h0;
  int          resp_cnt = 0;
  logic [31:0] resp_addr = 32'h0, resp_data = 32'h0;
  logic        resp_kill = 1'b0;

  // samples of the current cycle
  logic        s_req, s_fh, s_valid, s_rvalid;
  logic [31:0] s_baddr, s_inst, s_iaddr;

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } exp_t;
  exp_t exp_q[$];
  int   n_pops = 0;

  typedef struct {
    logic hold; logic ready;
    logic e_req; logic e_fh; logic e_valid;
    logic [31:0] e_baddr; logic [31:0] e_iaddr;
  } vec_t;
  vec_t tv[8];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    exp_t e;
    logic granted;
    @(negedge clk);
    rst_n        = k_rst_n;
    pc_i         = pc_m;
    jump_flag_i  = k_jump;
    hold_flag_i  = k_hold;
    inst_ready_i = k_ready;
    ibus_gnt_i   = 1'b1;
    s_rvalid      = k_rst_n && (resp_cnt == 1);
    ibus_rvalid_i = s_rvalid;
    ibus_rdata_i  = s_rvalid ? resp_data : 32'h0;
    if (s_rvalid && !resp_kill && !k_jump) begin
      e.addr = resp_addr;
      e.data = resp_data;
      exp_q.push_back(e);
    end
    #1;
    s_req = ibus_req_o; s_fh = fetch_hold_o; s_valid = inst_valid_o;
    s_baddr = ibus_addr_o; s_inst = inst_o; s_iaddr = inst_addr_o;
    if (k_rst_n) begin
      chk("fetch_hold", 32'(s_fh), 32'(!s_req));
      if (!s_valid) begin
        chk("idle_inst", s_inst, NOP);
        chk("idle_inst_addr", s_iaddr, 32'h0);
      end else if (k_ready && !k_jump) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_inst: got addr %h data %h expected no instruction", s_iaddr, s_inst);
        end else begin
          e = exp_q.pop_front();
          chk("inst_addr", s_iaddr, e.addr);
          chk("inst_data", s_inst, e.data);
          n_pops++;
        end
      end
    end
    if (k_jump || !k_rst_n) exp_q.delete();
    granted = k_rst_n && s_req;
    if (!k_rst_n) begin
      pc_m = 32'h0;
      resp_cnt = 0;
    end else begin
      if (k_jump && resp_cnt > 1) begin
        resp_kill = 1'b1;
        resp_data = 32'hDEADBEEF;
      end
      if (resp_cnt > 0) resp_cnt = resp_cnt - 1;
      if (granted) begin
        resp_cnt  = lat;
        resp_addr = s_baddr;
        resp_kill = k_jump;
        resp_data = memf(s_baddr);
      end
      if (k_jump) pc_m = k_target;
      else if (!s_fh) pc_m = pc_m + 32'd4;
    end
  endtask

  task automatic do_reset();
    k_rst_n = 1'b0; k_jump = 1'b0; k_hold = 1'b0;
    cyc();
    cyc();
    k_rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    logic found;
    int   n0;
    rst_n = 1'b0; pc_i = 32'h0; jump_flag_i = 1'b0; hold_flag_i = 1'b0;
    ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0; ibus_rdata_i = 32'h0; inst_ready_i = 1'b0;

    //         hold  rdy  req  fh   vld  bus addr     inst addr
    tv[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  32'h0};
    tv[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0};
    tv[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  32'h0};
    tv[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h4,  32'h0};
    tv[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  32'h0};
    tv[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h8,  32'h4};
    tv[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  32'h0};
    tv[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hC,  32'h8};

    // 1: streaming fetch, reset state in the first row
    lat = 1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      k_hold = tv[i].hold; k_ready = tv[i].ready;
      cyc();
      chk($sformatf("t1[%0d] req", i), 32'(s_req), 32'(tv[i].e_req));
      chk($sformatf("t1[%0d] fetch_hold", i), 32'(s_fh), 32'(tv[i].e_fh));
      chk($sformatf("t1[%0d] valid", i), 32'(s_valid), 32'(tv[i].e_valid));
      if (tv[i].e_req)   chk($sformatf("t1[%0d] bus_addr", i), s_baddr, tv[i].e_baddr);
      if (tv[i].e_valid) chk($sformatf("t1[%0d] inst_addr", i), s_iaddr, tv[i].e_iaddr);
    end

    // 2: FIFO full back-pressure
    lat = 1; k_ready = 1'b0;
    do_reset();
    repeat (5) cyc();
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("t2 full req", 32'(s_req), 32'h0);
      chk("t2 full fetch_hold", 32'(s_fh), 32'h1);
      chk("t2 full valid", 32'(s_valid), 32'h1);
      chk("t2 full head", s_iaddr, 32'h0);
    end
    n0 = n_pops;
    k_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      cyc();
      if (s_req) found = 1'b1;
    end
    chk("t2 resume", 32'(found), 32'h1);
    chk("t2 resume addr", s_baddr, 32'h8);
    chk("t2 drained", 32'(n_pops - n0), 32'd2);
    repeat (4) cyc();

    // 3: jump while WAIT, late response dropped
    lat = 3; k_ready = 1'b1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      if (s_req && s_baddr == 32'h8) found = 1'b1;
    end
    chk("t3 grant 0x8 seen", 32'(found), 32'h1);
    k_jump = 1'b1; k_target = 32'h100;
    cyc();
    k_jump = 1'b0;
    cyc();
    chk("t3 valid after jump", 32'(s_valid), 32'h0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (s_valid) found = 1'b1;
    end
    chk("t3 next inst seen", 32'(found), 32'h1);
    chk("t3 next inst addr", s_iaddr, 32'h100);
    chk("t3 dropped word absent", 32'(s_inst == 32'hDEADBEEF), 32'h0);

    // 4: jump coincident with rvalid and one buffered entry
    lat = 1; k_ready = 1'b0;
    do_reset();
    repeat (4) cyc();
    k_jump = 1'b1; k_target = 32'h200;
    cyc();
    chk("t4 rvalid at jump", 32'(s_rvalid), 32'h1);
    chk("t4 valid at jump", 32'(s_valid), 32'h1);
    k_jump = 1'b0;
    cyc();
    chk("t4 valid after jump", 32'(s_valid), 32'h0);
    chk("t4 inst after jump", s_inst, NOP);
    chk("t4 reissue req", 32'(s_req), 32'h1);
    chk("t4 reissue addr", s_baddr, 32'h200);
    k_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc();
      if (s_valid) found = 1'b1;
    end
    chk("t4 next inst seen", 32'(found), 32'h1);
    chk("t4 next inst addr", s_iaddr, 32'h200);

    // 5: hold during WAIT
    lat = 3; k_ready = 1'b1;
    do_reset();
    cyc();
    cyc();
    chk("t5 first req", 32'(s_req), 32'h1);
    chk("t5 first addr", s_baddr, 32'h0);
    k_hold = 1'b1;
    n0 = n_pops;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("t5 held req", 32'(s_req), 32'h0);
    end
    chk("t5 response enqueued", 32'(n_pops - n0), 32'd1);
    k_hold = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      cyc();
      if (s_req) found = 1'b1;
    end
    chk("t5 resume", 32'(found), 32'h1);
    chk("t5 resume addr", s_baddr, 32'h4);

    // 6: reset pulse mid-WAIT
    lat = 3; k_ready = 1'b0;
    do_reset();
    repeat (6) cyc();
    chk("t6 pre valid", 32'(s_valid), 32'h1);
    chk("t6 pre req", 32'(s_req), 32'h1);
    k_rst_n = 1'b0;
    cyc();
    k_rst_n = 1'b1;
    cyc();
    chk("t6 valid", 32'(s_valid), 32'h0);
    chk("t6 inst", s_inst, NOP);
    chk("t6 inst addr", s_iaddr, 32'h0);
    chk("t6 req", 32'(s_req), 32'h0);
    chk("t6 fetch_hold", 32'(s_fh), 32'h1);
    cyc();
    chk("t6 restart req", 32'(s_req), 32'h1);
    chk("t6 restart addr", s_baddr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
